jt6295_rom_arb: RTL and testbench

JT6295_ROM_ARB -- requirements
Module: jt6295_rom_arb

---
 rtl/jt6295_rom_arb.sv | 106 ++++++++++
 tb/tb_jt6295_rom_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt6295_rom_arb.sv
// Five-way ROM read arbiter with a one-entry hit cache per requester; misses take 3 cycles minimum.
// Backpressure: a requester simply holds req_cs until req_ok; the ROM side waits on rom_ok with no timeout.
module jt6295_rom_arb #(
  parameter int AW = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      req_cs,
  input  logic [5*AW-1:0] req_addr,
  output logic [4:0]      req_ok,
  output logic [39:0]     req_data,
  output logic [AW-1:0]   rom_addr,
  output logic            rom_cs,
  input  logic [7:0]      rom_data,
  input  logic            rom_ok,
  output logic [2:0]      grant
);

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT} state_t;

  state_t        st;
  logic [AW-1:0] tag [5];
  logic [7:0]    data [5];
  logic [4:0]    valid;
  logic [2:0]    rr;
  logic [4:0]    pending;
  logic          pick_vld;
  logic [2:0]    pick;
  logic [AW-1:0] pick_addr;

  always_comb begin
    req_ok   = '0;
    req_data = '0;
    for (int i = 0; i < 5; i++) begin
      req_ok[i]          = req_cs[i] & valid[i] & (tag[i] == req_addr[i*AW +: AW]);
      req_data[i*8 +: 8] = data[i];
    end
  end

  assign pending = req_cs & ~req_ok;

  // Control always wins; channels rotate starting just after the last granted channel.
  always_comb begin
    logic [2:0] cand;
    pick_vld = 1'b0;
    pick     = 3'd0;
    cand     = 3'd0;
    if (pending[0]) begin
      pick_vld = 1'b1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        cand = 3'(((rr - 3'd1 + 3'(k)) & 3'd3) + 3'd1);
        if (!pick_vld && pending[cand]) begin
          pick_vld = 1'b1;
          pick     = cand;
        end
      end
    end
  end

  assign pick_addr = req_addr[pick*AW +: AW];

  // rom_addr doubles as the latched fetch address, so the tag is written from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      grant    <= 3'd7;
      rr       <= 3'd4;
      valid    <= '0;
      for (int i = 0; i < 5; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      case (st)
        IDLE: begin
          if (pick_vld) begin
            rom_addr <= pick_addr;
            rom_cs   <= 1'b1;
            grant    <= pick;
            if (pick != 3'd0) rr <= pick;
            st       <= SETTLE;
          end else begin
            rom_cs <= 1'b0;
            grant  <= 3'd7;
          end
        end
        SETTLE: st <= WAIT;
        WAIT: begin
          if (rom_ok) begin
            data[grant]  <= rom_data;
            tag[grant]   <= rom_addr;
            valid[grant] <= 1'b1;
            rom_cs       <= 1'b0;
            grant        <= 3'd7;
            st           <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt6295_rom_arb.sv
// Bench for jt6295_rom_arb: behavioural ROM with configurable latency, grant/address scoreboard.
module tb_jt6295_rom_arb;
  localparam int AW = 18;

  logic            clk;
  logic            rst_n;
  logic [4:0]      req_cs;
  logic [5*AW-1:0] req_addr;
  logic [4:0]      req_ok;
  logic [39:0]     req_data;
  logic [AW-1:0]   rom_addr;
  logic            rom_cs;
  logic [7:0]      rom_data;
  logic            rom_ok;
  logic [2:0]      grant;

  typedef struct packed {
    logic [2:0]    g;
    logic [AW-1:0] a;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   rom_lat = 2;
  bit   rom_stale = 0;

  jt6295_rom_arb #(.AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_cs   (req_cs),
    .req_addr (req_addr),
    .req_ok   (req_ok),
    .req_data (req_data),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .grant    (grant)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] rom_fn(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h78;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic set_req(input int i, input bit cs, input logic [AW-1:0] a);
    req_cs[i] = cs;
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic push_exp(input logic [2:0] g, input logic [AW-1:0] a);
    exp_q.push_back({g, a});
  endtask

  task automatic wait_mask(input logic [4:0] m, input int budget, output int cyc);
    cyc = 0;
    while (((req_ok & m) != m) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("wait_ok_timeout", 32'((req_ok & m) == m), 1);
  endtask

  task automatic wait_cs(input int budget);
    int n;
    n = 0;
    while (!rom_cs && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_cs_timeout", 32'(rom_cs), 1);
  endtask

  // ROM: rom_ok rises rom_lat edges after rom_cs; stale mode holds rom_ok high with junk data early.
  initial begin
    int cnt;
    cnt = 0;
    rom_ok = 0;
    rom_data = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rom_cs) cnt = 0;
      else if (cnt < rom_lat) cnt++;
      rom_ok = rom_stale || (rom_cs && cnt >= rom_lat);
      if (rom_cs) rom_data = (cnt >= rom_lat) ? rom_fn(rom_addr) : 8'hEE;
    end
  end

  // Every new ROM access must match the next expected grant/address.
  initial begin
    logic prev;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge clk);
      if (rom_cs && !prev) begin
        check("access_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("grant_order", 32'(grant), 32'(e.g));
          check("rom_addr", 32'(rom_addr), 32'(e.a));
        end
      end
      prev = rom_cs;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [AW-1:0] aa [5];
    rst_n = 0;
    req_cs = '0;
    req_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_rom_cs", 32'(rom_cs), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_grant", 32'(grant), 7);
    check("rst_req_ok", 32'(req_ok), 0);
    check("rst_req_data", req_data[31:0] | 32'(req_data[39:32]), 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_grant", 32'(grant), 7);

    // single miss then zero-latency re-hit
    push_exp(3'd1, 18'h00123);
    set_req(1, 1, 18'h00123);
    #1;
    wait_mask(5'b00010, 20, cyc);
    check("miss_latency", cyc, 3);
    check("miss_data", 32'(req_data[15:8]), 32'h5A);
    set_req(1, 0, 18'h00123);
    #1;
    check("drop_ok", 32'(req_ok[1]), 0);
    set_req(1, 1, 18'h00123);
    #1;
    check("rehit_ok", 32'(req_ok[1]), 1);
    @(negedge clk);
    check("rehit_no_fetch", 32'(rom_cs), 0);

    // stale rom_ok held high
    rom_stale = 1;
    push_exp(3'd3, 18'h2A5F0);
    set_req(3, 1, 18'h2A5F0);
    #1;
    wait_mask(5'b01000, 20, cyc);
    check("stale_latency", cyc, 3);
    check("stale_data", 32'(req_data[31:24]), 32'(rom_fn(18'h2A5F0)));
    rom_stale = 0;
    @(negedge clk);

    // priority / round-robin from reset
    rst_n = 0;
    req_cs = '0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    aa[0] = 18'h00010; aa[1] = 18'h01111; aa[2] = 18'h02222; aa[3] = 18'h13333; aa[4] = 18'h3C444;
    for (int i = 0; i < 5; i++) push_exp(3'(i), aa[i]);
    for (int i = 0; i < 5; i++) set_req(i, 1, aa[i]);
    #1;
    wait_mask(5'h1F, 100, cyc);
    for (int i = 0; i < 5; i++) check("rr1_data", 32'(req_data[i*8 +: 8]), 32'(rom_fn(aa[i])));

    @(negedge clk);
    for (int i = 0; i < 5; i++) aa[i] = aa[i] ^ 18'h00F0F;
    for (int i = 0; i < 5; i++) push_exp(3'(i), aa[i]);
    for (int i = 0; i < 5; i++) set_req(i, 1, aa[i]);
    #1;
    wait_mask(5'h1F, 100, cyc);
    for (int i = 0; i < 5; i++) check("rr2_data", 32'(req_data[i*8 +: 8]), 32'(rom_fn(aa[i])));

    @(negedge clk);
    aa[2] = 18'h05A5A;
    push_exp(3'd2, aa[2]);
    set_req(2, 1, aa[2]);
    #1;
    wait_mask(5'b00100, 30, cyc);
    @(negedge clk);
    aa[0] = 18'h00777; aa[1] = 18'h01888; aa[3] = 18'h03999;
    push_exp(3'd0, aa[0]);
    push_exp(3'd3, aa[3]);
    push_exp(3'd1, aa[1]);
    set_req(0, 1, aa[0]);
    set_req(1, 1, aa[1]);
    set_req(3, 1, aa[3]);
    #1;
    wait_mask(5'b01011, 60, cyc);
    check("rr3_data1", 32'(req_data[15:8]), 32'(rom_fn(aa[1])));
    check("rr3_data3", 32'(req_data[31:24]), 32'(rom_fn(aa[3])));

    // address change during WAIT
    @(negedge clk);
    rom_lat = 5;
    push_exp(3'd2, 18'h00400);
    set_req(2, 1, 18'h00400);
    #1;
    wait_cs(10);
    @(negedge clk);
    push_exp(3'd2, 18'h00401);
    set_req(2, 1, 18'h00401);
    cyc = 0;
    while (grant != 3'd7 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("chg_done", 32'(grant), 7);
    check("chg_ok_stale_tag", 32'(req_ok[2]), 0);
    check("chg_data_old", 32'(req_data[23:16]), 32'h7C);
    wait_mask(5'b00100, 40, cyc);
    check("chg_data_new", 32'(req_data[23:16]), 32'h7D);

    // reset during WAIT
    @(negedge clk);
    rom_lat = 20;
    push_exp(3'd4, 18'h3FFFF);
    set_req(4, 1, 18'h3FFFF);
    #1;
    wait_cs(10);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("midrst_rom_cs", 32'(rom_cs), 0);
    check("midrst_grant", 32'(grant), 7);
    check("midrst_req_ok", 32'(req_ok), 0);
    check("midrst_req_data", req_data[31:0] | 32'(req_data[39:32]), 0);
    req_cs = 5'b10000;
    @(negedge clk);
    rom_lat = 2;
    push_exp(3'd4, 18'h3FFFF);
    rst_n = 1;
    @(negedge clk);
    check("rel_rom_cs", 32'(rom_cs), 1);
    check("rel_grant", 32'(grant), 4);
    wait_mask(5'b10000, 20, cyc);
    check("rel_data", 32'(req_data[39:32]), 32'h7B);

    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
